// File: rtl/migration_sequencer.sv
// rtl/migration_sequencer.sv - stream-migration episode sequencer (optional stats: MIGRATION_SEQ_STATS_EN)
module migration_sequencer #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TMR_WIDTH      = 17
) (
  input  logic       axis_aclk,
  input  logic       axis_reset,
  input  logic       cmd_start,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_port,
  input  logic       cmd_release,
  input  logic       cmd_abort,
  input  logic       migration_ready,
  input  logic       buf_empty,
  input  logic       buf_wr_beat,
  output logic       migration_progress,
  output logic [1:0] buffering_type,
  output logic [7:0] buffering_port,
  output logic       busy,
  output logic       done,
`ifdef MIGRATION_SEQ_STATS_EN
  output logic [31:0] stat_beats,
  output logic [31:0] stat_drain_cycles,
`endif
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_BUFFER = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [TMR_WIDTH-1:0] WD_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               next_state;
  logic [TMR_WIDTH-1:0] wdog;
  logic [TMR_WIDTH-1:0] wdog_d;
  logic [1:0]           type_d;
  logic [7:0]           port_d;
  logic                 error_d;
  logic                 progress_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 start_legal;

  // Only NONE-free types with a non-empty port mask start an episode.
  assign start_legal = ((cmd_type == 2'd1) || (cmd_type == 2'd3)) && (cmd_port != 8'd0);

  // State register.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) state <= S_IDLE;
    else            state <= next_state;
  end

  // Next-state logic; outputs are derived from the next state so they register with it.
  always_comb begin
    next_state = state;
    type_d     = buffering_type;
    port_d     = buffering_port;
    error_d    = error;
    wdog_d     = '0;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          if (start_legal) begin
            next_state = S_ARM;
            type_d     = cmd_type;
            port_d     = cmd_port;
            error_d    = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (cmd_abort) begin
          next_state = S_IDLE;
          error_d    = 1'b1;
        end else begin
          next_state = S_BUFFER;
        end
      end
      S_BUFFER: begin
        if (cmd_abort) begin
          next_state = S_IDLE;
          error_d    = 1'b1;
        end else if (cmd_release) begin
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cmd_abort) begin
          next_state = S_IDLE;
          error_d    = 1'b1;
        end else if (migration_ready && buf_empty) begin
          // Clean completion wins over a watchdog expiring in the same cycle.
          next_state = S_DONE;
        end else if (wdog == WD_LAST) begin
          next_state = S_DONE;
          error_d    = 1'b1;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (next_state == S_IDLE) begin
      type_d = 2'd0;
      port_d = 8'd0;
    end
    progress_d = (next_state == S_ARM) || (next_state == S_BUFFER);
    busy_d     = (next_state != S_IDLE);
    done_d     = (next_state == S_DONE);
  end

  // Registered outputs and drain watchdog.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      migration_progress <= 1'b0;
      buffering_type     <= 2'd0;
      buffering_port     <= 8'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      wdog               <= '0;
    end else begin
      migration_progress <= progress_d;
      buffering_type     <= type_d;
      buffering_port     <= port_d;
      busy               <= busy_d;
      done               <= done_d;
      error              <= error_d;
      wdog               <= wdog_d;
    end
  end

`ifdef MIGRATION_SEQ_STATS_EN
  logic start_accept;
  assign start_accept = (state == S_IDLE) && cmd_start && start_legal;

  // Beat counter over the buffering window and drain-length capture on leaving DRAIN.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset || start_accept) begin
      stat_beats        <= 32'd0;
      stat_drain_cycles <= 32'd0;
    end else begin
      if (buf_wr_beat && ((state == S_BUFFER) || (state == S_DRAIN)) &&
          (stat_beats != 32'hFFFF_FFFF)) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if ((state == S_DRAIN) && (next_state != S_DRAIN)) begin
        // wdog counts from 0 on the first DRAIN cycle, so cycles spent is wdog+1.
        stat_drain_cycles <= 32'(wdog) + 32'd1;
      end
    end
  end
`else
  logic unused_beat;
  assign unused_beat = buf_wr_beat;
`endif

endmodule

// File: tb/tb_migration_sequencer.sv
// tb/tb_migration_sequencer.sv - directed self-checking bench for migration_sequencer
module tb_migration_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_start;
  logic [1:0] cmd_type;
  logic [7:0] cmd_port;
  logic       cmd_release;
  logic       cmd_abort;
  logic       migration_ready;
  logic       buf_empty;
  logic       buf_wr_beat;
  logic       migration_progress;
  logic [1:0] buffering_type;
  logic [7:0] buffering_port;
  logic       busy;
  logic       done;
  logic       error;
`ifdef MIGRATION_SEQ_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_drain_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  migration_sequencer #(
    .TIMEOUT_CYCLES(16),
    .TMR_WIDTH(5)
  ) dut (
    .axis_aclk          (clk),
    .axis_reset         (rst),
    .cmd_start          (cmd_start),
    .cmd_type           (cmd_type),
    .cmd_port           (cmd_port),
    .cmd_release        (cmd_release),
    .cmd_abort          (cmd_abort),
    .migration_ready    (migration_ready),
    .buf_empty          (buf_empty),
    .buf_wr_beat        (buf_wr_beat),
    .migration_progress (migration_progress),
    .buffering_type     (buffering_type),
    .buffering_port     (buffering_port),
    .busy               (busy),
    .done               (done),
`ifdef MIGRATION_SEQ_STATS_EN
    .stat_beats         (stat_beats),
    .stat_drain_cycles  (stat_drain_cycles),
`endif
    .error              (error)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int prog_cnt;
  int n;

  initial begin
    rst = 1'b1; cmd_start = 0; cmd_type = 0; cmd_port = 0; cmd_release = 0;
    cmd_abort = 0; migration_ready = 0; buf_empty = 0; buf_wr_beat = 0;
    step(); step();
    chk("rst_progress", 32'(migration_progress), 0);
    chk("rst_type",     32'(buffering_type), 0);
    chk("rst_port",     32'(buffering_port), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_error",    32'(error), 0);
`ifdef MIGRATION_SEQ_STATS_EN
    chk("rst_stat_beats", stat_beats, 0);
`endif
    rst = 1'b0;
    step();

    // Release in IDLE is ignored.
    cmd_release = 1; step(); cmd_release = 0;
    chk("idle_release_busy", 32'(busy), 0);

    // Normal episode: start on c0, release sampled on c10, drain completes at once.
    migration_ready = 1; buf_empty = 1;
    cmd_start = 1; cmd_type = 2'd3; cmd_port = 8'h01;
    step();
    cmd_start = 0; cmd_type = 0; cmd_port = 0;
    chk("ep_arm_progress", 32'(migration_progress), 1);
    chk("ep_arm_type",     32'(buffering_type), 3);
    chk("ep_arm_port",     32'(buffering_port), 8'h01);
    chk("ep_arm_busy",     32'(busy), 1);
    prog_cnt = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (migration_progress === 1'b1) prog_cnt++;
    end
    cmd_release = 1;
    step();
    cmd_release = 0;
    if (migration_progress === 1'b1) prog_cnt++;
    chk("ep_drain_progress", 32'(migration_progress), 0);
    chk("ep_drain_type",     32'(buffering_type), 3);
    chk("ep_drain_done",     32'(done), 0);
    step();
    chk("ep_done_pulse", 32'(done), 1);
    chk("ep_done_busy",  32'(busy), 1);
    chk("ep_done_port",  32'(buffering_port), 8'h01);
    step();
    chk("ep_prog_cycles", prog_cnt, 10);
    chk("ep_idle_done",  32'(done), 0);
    chk("ep_idle_busy",  32'(busy), 0);
    chk("ep_idle_type",  32'(buffering_type), 0);
    chk("ep_idle_port",  32'(buffering_port), 0);
    chk("ep_idle_error", 32'(error), 0);

    // Illegal starts set error; a legal one clears it.
    cmd_start = 1; cmd_type = 2'd2; cmd_port = 8'h01;
    step();
    chk("ill_type_error", 32'(error), 1);
    chk("ill_type_busy",  32'(busy), 0);
    cmd_type = 2'd1; cmd_port = 8'h00;
    step();
    chk("ill_port_busy",  32'(busy), 0);
    cmd_type = 2'd1; cmd_port = 8'h02;
    step();
    cmd_start = 0;
    chk("legal_error",    32'(error), 0);
    chk("legal_busy",     32'(busy), 1);
    chk("legal_progress", 32'(migration_progress), 1);
    chk("legal_type",     32'(buffering_type), 1);
    chk("legal_port",     32'(buffering_port), 8'h02);
    // Abort in ARM.
    cmd_abort = 1; step(); cmd_abort = 0;
    chk("arm_abort_busy",  32'(busy), 0);
    chk("arm_abort_error", 32'(error), 1);
    chk("arm_abort_done",  32'(done), 0);
    chk("arm_abort_type",  32'(buffering_type), 0);

    // Watchdog: buffer never empties, done 16 cycles after DRAIN entry.
    buf_empty = 0;
    cmd_start = 1; cmd_type = 2'd3; cmd_port = 8'h80;
    step();
    cmd_start = 0;
    step();
    cmd_release = 1; step(); cmd_release = 0;
    chk("to_drain_busy", 32'(busy), 1);
    chk("to_drain_error", 32'(error), 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_error",   32'(error), 1);
    step();
    chk("to_idle_busy",  32'(busy), 0);
    chk("to_idle_error", 32'(error), 1);

    // Abort together with release in BUFFER.
    buf_empty = 1;
    cmd_start = 1; cmd_type = 2'd1; cmd_port = 8'h04;
    step();
    cmd_start = 0;
    step();
    chk("ab_buffer_progress", 32'(migration_progress), 1);
    cmd_abort = 1; cmd_release = 1;
    step();
    cmd_abort = 0; cmd_release = 0;
    chk("ab_busy",     32'(busy), 0);
    chk("ab_progress", 32'(migration_progress), 0);
    chk("ab_port",     32'(buffering_port), 0);
    chk("ab_error",    32'(error), 1);
    chk("ab_done",     32'(done), 0);
    step();
    chk("ab_done_after", 32'(done), 0);

    // Reset asserted in DRAIN.
    migration_ready = 0;
    cmd_start = 1; cmd_type = 2'd3; cmd_port = 8'h10;
    step();
    cmd_start = 0;
    step();
    cmd_release = 1; step(); cmd_release = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("rd_busy",  32'(busy), 0);
    chk("rd_done",  32'(done), 0);
    chk("rd_port",  32'(buffering_port), 0);
    step();
    chk("rd_done_after", 32'(done), 0);

`ifdef MIGRATION_SEQ_STATS_EN
    // 100 beats in BUFFER, 5 in DRAIN, drain lasts 7 cycles.
    migration_ready = 0; buf_empty = 0;
    cmd_start = 1; cmd_type = 2'd1; cmd_port = 8'h01;
    step();
    cmd_start = 0;
    step();
    buf_wr_beat = 1;
    for (int i = 0; i < 100; i++) step();
    buf_wr_beat = 0;
    cmd_release = 1; step(); cmd_release = 0;
    buf_wr_beat = 1;
    for (int i = 0; i < 5; i++) step();
    buf_wr_beat = 0;
    step();
    migration_ready = 1; buf_empty = 1;
    step();
    chk("st_done",  32'(done), 1);
    chk("st_beats", stat_beats, 105);
    chk("st_drain", stat_drain_cycles, 7);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
